// File: rtl/sd_block_capture.sv
// sd_block_capture: hunts the SD data-start token in the SD_SPI byte stream,
// stores one data block in an internal buffer and latches the trailing CRC16.
// The block is readable through a registered read port.
//
// Optional feature macro: SD_CRC_CHECK_EN
//   defined   -> CRC16-CCITT accumulator over the payload; mismatch gives Error=11
//   undefined -> no CRC logic; CRC bytes are still latched into BlockCrc
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for Start; incoming bytes ignored
// ST_HUNT   | looking for the 0xFE start token, counting 0xFF/filler bytes
// ST_DATA   | writing BLOCK_BYTES payload bytes into the buffer
// ST_CRC_HI | expecting the CRC high byte
// ST_CRC_LO | expecting the CRC low byte; capture ends here
module sd_block_capture #(
  parameter int BLOCK_BYTES   = 512,
  parameter int ADDR_W        = 9,
  parameter int TOKEN_TIMEOUT = 1024
) (
  input  logic              MasterCLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReq,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [7:0]        RdData,
  output logic              Busy,
  output logic              Done,
  output logic [1:0]        Error,
  output logic [15:0]       BlockCrc
);

  localparam int                HC_W      = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [HC_W-1:0]   HUNT_LOAD = HC_W'(TOKEN_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(BLOCK_BYTES - 1);
  localparam int                DEPTH     = 2 ** ADDR_W;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_TOKEN   = 2'b10;
  localparam logic [1:0] ERR_CRC     = 2'b11;

  localparam logic [7:0] START_TOKEN = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_DATA,
    ST_CRC_HI,
    ST_CRC_LO
  } state_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hunt_cnt_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [1:0]        error_q;
  logic              done_q;
  logic [15:0]       blockcrc_q;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem_q [DEPTH];

  // control strobes produced by the next-state logic
  logic       start_cap;
  logic       end_cap;
  logic [1:0] end_code;
  logic       hunt_dec;
  logic       wr_en;
  logic       crc_hi_en;
  logic       crc_lo_en;
  logic       crc_bad;

`ifdef SD_CRC_CHECK_EN
  logic [15:0] crc_q;

  // CRC16-CCITT (poly 0x1021), one byte folded in MSB first
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // payload CRC accumulator, cleared when a capture is armed
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      crc_q <= 16'h0000;
    end else if (start_cap) begin
      crc_q <= 16'h0000;
    end else if (wr_en) begin
      crc_q <= crc16_step(crc_q, ByteIn);
    end
  end

  // the low CRC byte is compared straight off the bus as it arrives
  always_comb begin
    crc_bad = (crc_q != {blockcrc_q[15:8], ByteIn});
  end
`else
  // without the checker a completed block always reports success
  always_comb begin
    crc_bad = 1'b0;
  end
`endif

  // FSM state register
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state and per-byte control decode
  always_comb begin
    state_d   = state_q;
    start_cap = 1'b0;
    end_cap   = 1'b0;
    end_code  = ERR_OK;
    hunt_dec  = 1'b0;
    wr_en     = 1'b0;
    crc_hi_en = 1'b0;
    crc_lo_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // a byte arriving with Start is dropped; only Start matters here
        if (Start) begin
          start_cap = 1'b1;
          state_d   = ST_HUNT;
        end
      end
      ST_HUNT: begin
        if (ByteValid) begin
          if (ByteIn == START_TOKEN) begin
            state_d = ST_DATA;
          end else if (ByteIn[7:5] == 3'b000) begin
            end_cap  = 1'b1;
            end_code = ERR_TOKEN;
            state_d  = ST_IDLE;
          end else if (hunt_cnt_q == '0) begin
            end_cap  = 1'b1;
            end_code = ERR_TIMEOUT;
            state_d  = ST_IDLE;
          end else begin
            hunt_dec = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (ByteValid) begin
          wr_en = 1'b1;
          if (ptr_q == LAST_PTR) state_d = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (ByteValid) begin
          crc_hi_en = 1'b1;
          state_d   = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (ByteValid) begin
          crc_lo_en = 1'b1;
          end_cap   = 1'b1;
          end_code  = crc_bad ? ERR_CRC : ERR_OK;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: byte requests and busy follow the registered state
  always_comb begin
    Busy    = (state_q != ST_IDLE);
    ByteReq = (state_q != ST_IDLE);
  end

  // capture datapath: hunt timer, write pointer, status and CRC latch
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      hunt_cnt_q <= HUNT_LOAD;
      ptr_q      <= '0;
      error_q    <= ERR_OK;
      done_q     <= 1'b0;
      blockcrc_q <= 16'h0000;
    end else begin
      done_q <= end_cap;
      if (start_cap) begin
        hunt_cnt_q <= HUNT_LOAD;
        ptr_q      <= '0;
        error_q    <= ERR_OK;
      end
      // down-counter reaching zero marks the last tolerated filler byte
      if (hunt_dec) hunt_cnt_q <= hunt_cnt_q - 1'b1;
      // pointer parks on the last address instead of wrapping
      if (wr_en && (ptr_q != LAST_PTR)) ptr_q <= ptr_q + 1'b1;
      if (end_cap)   error_q          <= end_code;
      if (crc_hi_en) blockcrc_q[15:8] <= ByteIn;
      if (crc_lo_en) blockcrc_q[7:0]  <= ByteIn;
    end
  end

  // block buffer write port; contents survive reset
  always_ff @(posedge MasterCLK) begin
    if (wr_en) mem_q[ptr_q] <= ByteIn;
  end

  // registered read port; a same-cycle write is seen on the next read
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) rd_data_q <= 8'h00;
    else        rd_data_q <= mem_q[RdAddr];
  end

  assign RdData   = rd_data_q;
  assign Done     = done_q;
  assign Error    = error_q;
  assign BlockCrc = blockcrc_q;

endmodule

// File: tb/tb_sd_block_capture.sv
// Randomized self-checking bench for sd_block_capture with a stream-level
// reference model (token search, payload slice, CRC16 over the payload).
module tb_sd_block_capture;

  localparam int BB = 512;
  localparam int AW = 9;
  localparam int TT = 16;

  typedef logic [7:0] byte_q_t [$];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    bin;
  logic          bvalid;
  logic          breq;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic [15:0]   bcrc;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ref_mem [BB];
  logic [BB-1:0] ref_known;
  logic [15:0] ref_bcrc;

  always #5 clk = ~clk;

  sd_block_capture #(
    .BLOCK_BYTES  (BB),
    .ADDR_W       (AW),
    .TOKEN_TIMEOUT(TT)
  ) dut (
    .MasterCLK(clk),
    .Reset    (rst_n),
    .Start    (start),
    .ByteIn   (bin),
    .ByteValid(bvalid),
    .ByteReq  (breq),
    .RdAddr   (rd_addr),
    .RdData   (rd_data),
    .Busy     (busy),
    .Done     (done),
    .Error    (err),
    .BlockCrc (bcrc)
  );

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // CRC16-CCITT, init 0, byte-at-a-time into the top of the register
  function automatic logic [15:0] crc_ref(input byte_q_t p);
    logic [15:0] c;
    c = 16'h0000;
    foreach (p[k]) begin
      c = c ^ {p[k], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
    for (int g = 0; g < gap; g++) begin
      bvalid = 1'b0;
      bin    = 8'($urandom);
      tick();
    end
    bin    = b;
    bvalid = 1'b1;
    start  = st;
    tick();
    bvalid = 1'b0;
    start  = 1'b0;
    bin    = 8'($urandom);
  endtask

  task automatic rd_check(input int addr);
    rd_addr = AW'(addr);
    tick();
    if (ref_known[addr]) check_eq($sformatf("rd_%0d", addr), 32'(rd_data), 32'(ref_mem[addr]));
  endtask

  // Arms a capture and plays the stream; the model decides where it ends.
  task automatic do_capture(input byte_q_t s, input int gap_max, input int restart_at,
                            input logic coincide);
    int          hunts;
    int          end_idx;
    int          data_idx;
    logic [1:0]  exp_err;
    logic [15:0] exp_crc;
    logic [7:0]  b;
    byte_q_t     pay;
    hunts    = 0;
    end_idx  = -1;
    data_idx = -1;
    exp_err  = 2'b00;
    exp_crc  = ref_bcrc;
    for (int i = 0; i < s.size() && end_idx < 0 && data_idx < 0; i++) begin
      b = s[i];
      if (b == 8'hFE) data_idx = i;
      else if (b[7:5] == 3'b000) begin
        end_idx = i;
        exp_err = 2'b10;
      end else begin
        hunts++;
        if (hunts == TT) begin
          end_idx = i;
          exp_err = 2'b01;
        end
      end
    end
    if (data_idx >= 0) begin
      pay     = s[data_idx+1 : data_idx+BB];
      exp_crc = {s[data_idx+BB+1], s[data_idx+BB+2]};
      end_idx = data_idx + BB + 2;
`ifdef SD_CRC_CHECK_EN
      exp_err = (crc_ref(pay) != exp_crc) ? 2'b11 : 2'b00;
`else
      exp_err = 2'b00;
`endif
    end
    if (end_idx < 0) return;

    start = 1'b1;
    if (coincide) begin
      bvalid = 1'b1;
      bin    = 8'hFE;
    end
    tick();
    start  = 1'b0;
    bvalid = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("req_after_start", 32'(breq), 32'd1);
    check_eq("err_cleared", 32'(err), 32'd0);

    for (int i = 0; i <= end_idx; i++) begin
      send_byte(s[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0, i == restart_at);
      if (data_idx >= 0 && i > data_idx && i <= data_idx + BB) begin
        ref_mem[i-data_idx-1]   = s[i];
        ref_known[i-data_idx-1] = 1'b1;
      end
      if (i < end_idx) check_eq("mid_done_busy", 32'({done, busy}), 32'b01);
    end
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("req_end", 32'(breq), 32'd0);
    check_eq("error_end", 32'(err), 32'(exp_err));
    check_eq("blockcrc_end", 32'(bcrc), 32'(exp_crc));
    ref_bcrc = exp_crc;
    tick();
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("error_persist", 32'(err), 32'(exp_err));
  endtask

  function automatic byte_q_t rand_block(input int hunt_n, input logic bad_crc);
    byte_q_t s;
    byte_q_t pay;
    logic [15:0] c;
    for (int i = 0; i < hunt_n; i++)
      s.push_back(($urandom_range(1, 0) != 0) ? 8'hFF : 8'($urandom_range(8'hFD, 8'h20)));
    s.push_back(8'hFE);
    for (int i = 0; i < BB; i++) pay.push_back(8'($urandom));
    s = {s, pay};
    c = crc_ref(pay);
    if (bad_crc) c = c ^ 16'($urandom_range(16'hFFFF, 1));
    s.push_back(c[15:8]);
    s.push_back(c[7:0]);
    return s;
  endfunction

  initial begin
    byte_q_t s;
    byte_q_t pay;
    logic [15:0] c;
    logic [7:0]  old5;
    logic [7:0]  nb;

    rst_n     = 1'b0;
    start     = 1'b0;
    bvalid    = 1'b0;
    bin       = 8'h00;
    rd_addr   = '0;
    ref_known = '0;
    ref_bcrc  = 16'h0000;
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_req", 32'(breq), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_crc", 32'(bcrc), 32'd0);
    check_eq("rst_rdata", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // bytes in IDLE are ignored
    for (int i = 0; i < 4; i++) begin
      send_byte((i == 0) ? 8'hFE : 8'($urandom), 0, 1'b0);
      check_eq("idle_ignore", 32'({done, busy, breq}), 32'd0);
    end

    // all-0xFF block, known CRC; byte coincident with Start is dropped
    s = {};
    repeat (3) s.push_back(8'hFF);
    s.push_back(8'hFE);
    repeat (BB) s.push_back(8'hFF);
    s.push_back(8'h7F);
    s.push_back(8'hA1);
    do_capture(s, 2, -1, 1'b1);
    rd_check(0);

    // counting payload, back-to-back strobes, Start mid-block is ignored
    s = {};
    s.push_back(8'hFE);
    pay = {};
    for (int i = 0; i < BB; i++) pay.push_back(8'(i));
    s = {s, pay};
    c = crc_ref(pay);
    s.push_back(c[15:8]);
    s.push_back(c[7:0]);
    do_capture(s, 0, 200, 1'b0);
    rd_check(300);
    rd_check(511);
    for (int i = 0; i < 4; i++) rd_check(int'($urandom_range(BB - 1, 0)));

    // hunt timeout on the TT-th filler byte; buffer untouched
    s = {};
    repeat (TT + 4) s.push_back(8'hFF);
    do_capture(s, 1, -1, 1'b0);
    rd_check(0);
    rd_check(300);

    // error token, then a clean block
    s = {};
    s.push_back(8'hFF);
    s.push_back(8'h05);
    do_capture(s, 0, -1, 1'b0);
    do_capture(rand_block(2, 1'b0), 1, -1, 1'b0);
    rd_check(17);

    // bad CRC on the all-0xFF block
    s = {};
    s.push_back(8'hFE);
    repeat (BB) s.push_back(8'hFF);
    s.push_back(8'h7F);
    s.push_back(8'hA0);
    do_capture(s, 0, -1, 1'b0);

    // randomized blocks: filler length, gaps, good/bad CRC
    for (int r = 0; r < 4; r++) begin
      do_capture(rand_block(int'($urandom_range(TT - 2, 0)), r[0]), 2, -1, 1'b0);
      for (int i = 0; i < 3; i++) rd_check(int'($urandom_range(BB - 1, 0)));
    end

    // reset in the middle of a block
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'hFE, 0, 1'b0);
    old5 = ref_mem[5];
    for (int k = 0; k < 100; k++) begin
      nb = ~ref_mem[k];
      if (k == 5) rd_addr = AW'(5);
      send_byte(nb, 0, 1'b0);
      ref_mem[k] = nb;
      if (k == 5) check_eq("rd_same_addr_old", 32'(rd_data), 32'(old5));
      if (k == 6) check_eq("rd_after_write_new", 32'(rd_data), 32'(nb ^ nb ^ ref_mem[5]));
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_req", 32'(breq), 32'd0);
    check_eq("midrst_err", 32'(err), 32'd0);
    check_eq("midrst_crc", 32'(bcrc), 32'd0);
    tick();
    rst_n    = 1'b1;
    ref_bcrc = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      check_eq("midrst_no_done", 32'({done, busy}), 32'd0);
      tick();
    end
    do_capture(rand_block(3, 1'b0), 1, -1, 1'b0);
    rd_check(0);
    rd_check(99);
    rd_check(511);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
